r2_mac_sequencer: RTL and testbench

- Upstream control stage for the single-precision multiply-add DSP block (result = ax*ay + az, fixed pipeline latency).
- Accepts one particle-pair displacement (dx, dy, dz) and issues three dependent mul-add operations on one shared MAC: dx*dx+0, then dy*dy+acc, then dz*dz+acc.
- Returns r2 = dx^2+dy^2+dz^2 with a cutoff flag and a passthrough tag to the range-limited force pipeline.

---
 rtl/r2_mac_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_r2_mac_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2_mac_sequencer.sv
// r2_mac_sequencer
// Control stage in front of a shared single-precision multiply-add block
// (result = ax*ay + az). It accepts one displacement (dx, dy, dz) and
// chains three mul-adds on the MAC: dx*dx+0, dy*dy+acc, dz*dz+acc. It then
// presents r2, a cutoff flag and the pair tag to the force pipeline.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       displacement handshake
//   in_dx/in_dy/in_dz       FP32 displacement components
//   in_tag                  pair identifier, passed through to out_tag
//   mac_ena                 MAC clock enable (always 1 outside reset)
//   mac_ax/mac_ay/mac_az    MAC operands
//   mac_result              MAC output, MAC_LATENCY cycles after the operands
//   out_valid/out_ready     result handshake
//   out_r2                  dx^2+dy^2+dz^2, FP32
//   out_in_range            r2 strictly below CUTOFF2 (never for NaN/Inf)
//   out_tag                 tag of this result
module r2_mac_sequencer #(
  parameter int          MAC_LATENCY = 4,
  parameter logic [31:0] CUTOFF2     = 32'h41800000,
  parameter int          TAG_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_dx,
  input  logic [31:0]      in_dy,
  input  logic [31:0]      in_dz,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mac_ena,
  output logic [31:0]      mac_ax,
  output logic [31:0]      mac_ay,
  output logic [31:0]      mac_az,
  input  logic [31:0]      mac_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r2,
  output logic             out_in_range,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [3:0] LAT = 4'(MAC_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       op;
  logic [1:0]       op_nxt;
  logic [3:0]       wait_cnt;
  logic [3:0]       wait_cnt_nxt;
  logic [31:0]      lat_dy;
  logic [31:0]      lat_dz;
  logic [TAG_W-1:0] lat_tag;
  logic             accept;
  logic             capture;

  // r2 is a sum of squares, so the magnitude bits order like an unsigned
  // integer; -0.0 has zero magnitude and is in range. NaN/Inf never are.
  function automatic logic in_range_of(input logic [31:0] v);
    if (v[30:23] == 8'hFF) begin
      return 1'b0;
    end else begin
      return (v[30:0] < CUTOFF2[30:0]);
    end
  endfunction

  assign accept  = in_valid & in_ready;
  // Capture is keyed only to the wait counter, so whatever the MAC pipeline
  // held from an aborted pair is never sampled.
  assign capture = (state == S_WAIT) && (wait_cnt == LAT);

  // State register, operation index and wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op       <= 2'd0;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      op       <= op_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic: IDLE -> (ISSUE -> WAIT) x3 -> DONE -> IDLE
  always_comb begin
    state_nxt    = state;
    op_nxt       = op;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_ISSUE;
          op_nxt    = 2'd0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_nxt    = S_WAIT;
        wait_cnt_nxt = 4'd1;
      end
      S_WAIT: begin
        if (capture) begin
          if (op == 2'd2) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ISSUE;
            op_nxt    = op + 2'd1;
          end
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs and operand/accumulator datapath. The running sum
  // lives in mac_az (next addend) and finally in out_r2, so no separate
  // accumulator register is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready     <= 1'b0;
      mac_ena      <= 1'b0;
      mac_ax       <= 32'd0;
      mac_ay       <= 32'd0;
      mac_az       <= 32'd0;
      out_valid    <= 1'b0;
      out_r2       <= 32'd0;
      out_in_range <= 1'b0;
      out_tag      <= {TAG_W{1'b0}};
      lat_dy       <= 32'd0;
      lat_dz       <= 32'd0;
      lat_tag      <= {TAG_W{1'b0}};
    end else begin
      mac_ena   <= 1'b1;
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_DONE);
      if (accept) begin
        lat_dy  <= in_dy;
        lat_dz  <= in_dz;
        lat_tag <= in_tag;
        mac_ax  <= in_dx;
        mac_ay  <= in_dx;
        mac_az  <= 32'd0;
      end
      if (capture) begin
        case (op)
          2'd0: begin
            mac_ax <= lat_dy;
            mac_ay <= lat_dy;
            mac_az <= mac_result;
          end
          2'd1: begin
            mac_ax <= lat_dz;
            mac_ay <= lat_dz;
            mac_az <= mac_result;
          end
          default: begin
            out_r2       <= mac_result;
            out_in_range <= in_range_of(mac_result);
            out_tag      <= lat_tag;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_r2_mac_sequencer.sv
// Self-checking bench for r2_mac_sequencer. Two instances: the default
// MAC_LATENCY=4 build under directed and random stimulus, and a
// MAC_LATENCY=2 build for the latency-parameter cases. Each has a
// behavioural MAC (real arithmetic behind a delay line).
module tb_r2_mac_sequencer;

  localparam int L  = 4;
  localparam int L2 = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, mac_ena, out_valid, out_ready, out_in_range;
  logic [31:0] in_dx, in_dy, in_dz, mac_ax, mac_ay, mac_az, mac_result, out_r2;
  logic [7:0]  in_tag, out_tag;

  logic        b_in_valid, b_in_ready, b_mac_ena, b_out_valid, b_out_ready, b_out_in_range;
  logic [31:0] b_in_dx, b_in_dy, b_in_dz, b_mac_ax, b_mac_ay, b_mac_az, b_mac_result, b_out_r2;
  logic [7:0]  b_in_tag, b_out_tag;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  r2_mac_sequencer #(.MAC_LATENCY(L), .CUTOFF2(32'h41800000), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dx(in_dx), .in_dy(in_dy), .in_dz(in_dz), .in_tag(in_tag),
    .mac_ena(mac_ena), .mac_ax(mac_ax), .mac_ay(mac_ay), .mac_az(mac_az),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_r2(out_r2), .out_in_range(out_in_range), .out_tag(out_tag)
  );

  r2_mac_sequencer #(.MAC_LATENCY(L2), .CUTOFF2(32'h41800000), .TAG_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_dx(b_in_dx), .in_dy(b_in_dy), .in_dz(b_in_dz), .in_tag(b_in_tag),
    .mac_ena(b_mac_ena), .mac_ax(b_mac_ax), .mac_ay(b_mac_ay), .mac_az(b_mac_az),
    .mac_result(b_mac_result), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_r2(b_out_r2), .out_in_range(b_out_in_range), .out_tag(b_out_tag)
  );

  // FP32 <-> real conversion (denormals flush to zero; values used are exact)
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    int e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    if (e == 255) begin
      d = {b[31], 11'h7FF, b[22:0], 29'd0};
    end else begin
      e = e - 127 + 1023;
      d = {b[31], e[10:0], b[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 2047) return (d[51:0] != 52'd0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'd0};
    if (e == 0) return {d[63], 31'd0};
    e = e - 1023 + 127;
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] mac_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return r2f(f2r(a) * f2r(b) + f2r(c));
  endfunction

  // Random FP32 value k/2 with k in 0..15 and random sign (all squares exact)
  function automatic logic [31:0] rnd_fp();
    int k;
    real s;
    k = int'($urandom_range(0, 15));
    s = ($urandom_range(0, 1) != 0) ? -1.0 : 1.0;
    return r2f(s * real'(k) / 2.0);
  endfunction

  // Behavioural MACs: result appears exactly LAT cycles after the operands
  logic [31:0] pipe_a [L];
  logic [31:0] pipe_b [L2];
  always @(posedge clk) begin
    pipe_a[0] <= mac_fn(mac_ax, mac_ay, mac_az);
    for (int i = 1; i < L; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= mac_fn(b_mac_ax, b_mac_ay, b_mac_az);
    for (int i = 1; i < L2; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign mac_result   = pipe_a[L-1];
  assign b_mac_result = pipe_b[L2-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one pending pair at most; result due 3L+4 cycles
  // after the cycle in which the accept is sampled.
  typedef struct {
    logic [31:0] dx;
    logic [31:0] r2;
    logic        rng;
    logic [7:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_hist[$];
  logic        last_rst  = 1'b0;
  logic        prev_ov   = 1'b0;
  logic        exp_ready, exp_valid;
  int          acc_cyc   = 0;
  int          due       = 0;
  int          out_count = 0;
  int          acc_count = 0;
  int          lat_seen  = -1;
  logic [31:0] last_r2   = 32'd0;
  logic        last_rng  = 1'b0;
  logic [7:0]  last_tag  = 8'd0;

  always @(negedge clk) begin
    exp_t e;
    real  sum;
    if (cyc > 0) begin
      exp_ready = last_rst && (exp_q.size() == 0);
      exp_valid = last_rst && (exp_q.size() != 0) && (cyc >= due);
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, exp_valid);
      chk("mac_ena", mac_ena, last_rst);
      if (!last_rst) begin
        chk("rst_out_r2", out_r2, 32'd0);
        chk("rst_in_range", out_in_range, 1'b0);
        chk("rst_out_tag", out_tag, 8'd0);
        chk("rst_mac_ax", mac_ax, 32'd0);
        chk("rst_mac_az", mac_az, 32'd0);
      end
      if (out_valid && exp_q.size() != 0) begin
        chk("out_r2", out_r2, exp_q[0].r2);
        chk("out_in_range", out_in_range, exp_q[0].rng);
        chk("out_tag", out_tag, exp_q[0].tag);
      end
      if (out_valid && !prev_ov) lat_seen = cyc - acc_cyc;
      if (last_rst && exp_q.size() != 0 && cyc == acc_cyc + 1) begin
        chk("op0_ax", mac_ax, exp_q[0].dx);
        chk("op0_ay", mac_ay, exp_q[0].dx);
        chk("op0_az", mac_az, 32'd0);
      end
      if (rst_n) begin
        if (exp_valid && out_ready) begin
          e        = exp_q.pop_front();
          last_r2  = e.r2;
          last_rng = e.rng;
          last_tag = e.tag;
          out_count++;
        end else if (exp_ready && in_valid) begin
          sum   = f2r(in_dx) * f2r(in_dx) + f2r(in_dy) * f2r(in_dy) + f2r(in_dz) * f2r(in_dz);
          e.dx  = in_dx;
          e.r2  = r2f(sum);
          e.rng = (f2r(e.r2) < 16.0);
          e.tag = in_tag;
          exp_q.push_back(e);
          acc_cyc = cyc;
          due     = cyc + 3 * L + 4;
          acc_count++;
          acc_hist.push_back(cyc);
        end
      end else begin
        exp_q.delete();
      end
      prev_ov  = out_valid;
      last_rst = rst_n;
    end
  end

  // Present a pair and hold it until accepted (called just after a posedge)
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z, input logic [7:0] t);
    bit done;
    done     = 1'b0;
    in_dx    = x;
    in_dy    = y;
    in_dz    = z;
    in_tag   = t;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready && rst_n) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out(input int n, input bit rnd);
    int start;
    start = out_count;
    for (int i = 0; i < n && out_count == start; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    chk("out_count", 32'(out_count - start), 32'd1);
  endtask

  task automatic b_run(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                       input logic [7:0] t, input logic [31:0] er2, input logic erng);
    int   ac;
    int   lat;
    bit   seen;
    logic [31:0] r;
    logic        g;
    logic [7:0]  tg;
    ac = -1; lat = -1; seen = 1'b0; r = 32'd0; g = 1'b0; tg = 8'd0;
    b_in_dx = x; b_in_dy = y; b_in_dz = z; b_in_tag = t; b_in_valid = 1'b1;
    for (int i = 0; i < 50 && ac < 0; i++) begin
      @(negedge clk);
      if (b_in_ready) ac = cyc;
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (b_out_valid) begin
        seen = 1'b1; lat = cyc - ac; r = b_out_r2; g = b_out_in_range; tg = b_out_tag;
      end
    end
    chk("b_seen", 32'(seen), 32'd1);
    chk("b_latency", 32'(lat), 32'd10);
    chk("b_r2", r, er2);
    chk("b_in_range", g, erng);
    chk("b_tag", tg, t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int a0;
    logic [31:0] x, y, z;
    rst_n = 1'b0; in_valid = 1'b0; in_dx = 32'd0; in_dy = 32'd0; in_dz = 32'd0; in_tag = 8'd0;
    out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_dx = 32'd0; b_in_dy = 32'd0; b_in_dz = 32'd0; b_in_tag = 8'd0;
    b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1.0, 2.0, 2.0 -> 9.0, in range, 16-cycle latency
    send(32'h3F800000, 32'h40000000, 32'h40000000, 8'h5A);
    in_valid = 1'b0;
    wait_out(80, 1'b0);
    chk("pin_r2_9", last_r2, 32'h41100000);
    chk("pin_rng_9", last_rng, 1'b1);
    chk("pin_tag_5a", last_tag, 8'h5A);
    chk("pin_latency", 32'(lat_seen), 32'd16);

    // 3.0, 0, -4.0 -> 25.0, out of range
    send(32'h40400000, 32'h00000000, 32'hC0800000, 8'h11);
    in_valid = 1'b0;
    wait_out(80, 1'b0);
    chk("pin_r2_25", last_r2, 32'h41C80000);
    chk("pin_rng_25", last_rng, 1'b0);

    // 4.0, 0, 0 -> exactly 16.0: equality is out of range
    send(32'h40800000, 32'h00000000, 32'h00000000, 8'h22);
    in_valid = 1'b0;
    wait_out(80, 1'b0);
    chk("pin_r2_16", last_r2, 32'h41800000);
    chk("pin_rng_16", last_rng, 1'b0);

    // Consumer stall: 2.0,0,0 -> 4.0 held for 10 cycles, in_valid pulses ignored
    out_ready = 1'b0;
    send(32'h40000000, 32'h00000000, 32'h00000000, 8'h77);
    in_valid = 1'b0;
    for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
    chk("stall_valid", out_valid, 1'b1);
    base = out_count;
    a0   = acc_count;
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_r2", out_r2, 32'h40800000);
      chk("stall_tag", out_tag, 8'h77);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("stall_no_output", 32'(out_count - base), 32'd0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_one_output", 32'(out_count - base), 32'd1);
    chk("stall_no_accept", 32'(acc_count - a0), 32'd0);

    // Back-to-back pairs with out_ready high: accepts spaced 3L+5 apart
    acc_hist.delete();
    base = out_count;
    for (int j = 0; j < 4; j++) send(rnd_fp(), rnd_fp(), rnd_fp(), 8'(8'hA0 + j));
    in_valid = 1'b0;
    for (int i = 0; i < 100 && out_count < base + 4; i++) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_outputs", 32'(out_count - base), 32'd4);
    chk("b2b_accepts", 32'(acc_hist.size()), 32'd4);
    for (int i = 0; i < 3 && i + 1 < acc_hist.size(); i++)
      chk("b2b_spacing", 32'(acc_hist[i+1] - acc_hist[i]), 32'(3 * L + 5));

    // Reset during the op1 wait window, then a clean 1,1,1 pair
    send(32'h40000000, 32'h40000000, 32'h40000000, 8'h44);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 8'h66);
    in_valid = 1'b0;
    wait_out(80, 1'b0);
    chk("pin_r2_3", last_r2, 32'h40400000);
    chk("pin_tag_66", last_tag, 8'h66);
    chk("pin_latency_after_abort", 32'(lat_seen), 32'd16);

    // MAC_LATENCY=2 build: 10-cycle latency
    b_run(32'h00000000, 32'h00000000, 32'h00000000, 8'h33, 32'h00000000, 1'b1);
    b_run(32'h3F800000, 32'h40000000, 32'h40000000, 8'h34, 32'h41100000, 1'b1);

    // Random pairs with random consumer back-pressure and a few NaN/Inf inputs
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      x = rnd_fp(); y = rnd_fp(); z = rnd_fp();
      if ($urandom_range(0, 9) == 0) x = 32'h5F800000;
      if ($urandom_range(0, 14) == 0) y = 32'h7FC00000;
      send(x, y, z, 8'(n));
      in_valid = 1'b0;
      wait_out(300, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
